approx_mul_arbiter: RTL and testbench
=====================================

# approx_mul_arbiter

Round-robin arbiter and 2-stage pipeline controller that shares one combinational 8x8 approximate multiplier instance (any of the unsigned 8x8 exchange variants) among several requesters. Accepts operand pairs over per-requester valid/ready channels, drives the shared multiplier from a registered issue stage, captures the product, and returns it with the requester ID over a single backpressured response channel. It sits between the requester cores and the multiplier, so approximate units can be time-shared without per-requester copies.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- W, 8, operand width; product width is 2*W
- IDW, $clog2(NUM_REQ), requester ID width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_x  in  NUM_REQ*W  operand x of requester i at [i*W +: W]
- req_y  in  NUM_REQ*W  operand y of requester i at [i*W +: W]
- mul_x  out  W  to shared multiplier x; driven from stage-1 register
- mul_y  out  W  to shared multiplier y; driven from stage-1 register
- mul_z  in  2*W  combinational product from shared multiplier
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester index of the response
- rsp_z  out  2*W  product

## Operation
- Arbitration: round-robin. last_grant pointer; search starts at last_grant+1 modulo NUM_REQ and takes the first i with req_valid[i]. Grant is combinational from req_valid and last_grant.
- req_ready[i] = grant[i] & s1_load. Handshake = req_valid[i] & req_ready[i]. last_grant updates to i only on a handshake; otherwise held.
- Stage 1 (s1): registers x, y, id, s1_valid. mul_x/mul_y = s1 x/y.
- Stage 2 (s2): registers mul_z, s1 id, s2_valid; outputs rsp_z, rsp_id, rsp_valid = s2_valid.
- Advance rules: s2_load = !s2_valid | rsp_ready; s1_load = !s1_valid | s2_load.
- On s2_load: s2 <= s1 contents (s2_valid <= s1_valid). On s1_load: s1 <= granted operands if a handshake occurs, else s1_valid <= 0.
- Stall: rsp_valid & !rsp_ready with s1_valid high -> all req_ready low, s1/s2 and mul_x/mul_y hold.
- Product is passed through unmodified (no rounding, no truncation); width 2*W; approximation error belongs to the multiplier.
- Requester rules: req_valid, once high, holds with stable operands until the handshake; req_valid must not depend on req_ready.
- Responses leave in acceptance order; no reordering, no drops.

## Timing
- Reset (rst high at a clock edge): s1_valid=0, s2_valid=0, rsp_valid=0, rsp_z=0, rsp_id=0, mul_x=0, mul_y=0, last_grant=NUM_REQ-1 (requester 0 has top priority first). req_ready is all-zero during the reset cycle.
- Latency: handshake at edge N -> s1 at N; rsp_valid high after edge N+1 (2 cycles from acceptance to response).
- Throughput: 1 operation per cycle with rsp_ready held high.
- Reset mid-operation: in-flight s1/s2 contents are discarded without response; pointer returns to reset value.
- Pointer wrap: after grant to NUM_REQ-1, search restarts at 0.
- A single active requester gets back-to-back grants every cycle.
- rsp_ready rising in the same cycle s1 holds data: s2 and s1 both advance and a new request is accepted that cycle.

## Test plan
- Single request: req 2 valid, x=200, y=150 -> req_ready[2] high same cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_z equals the multiplier model output for 200*150 (exact model: 30000).
- All 4 requesters valid from reset, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; responses carry IDs 0,1,2,3 on consecutive cycles.
- Backpressure: rsp_ready=0 for 5 cycles with 3 requesters active -> at most 2 accepted, then req_ready all 0; rsp_z/rsp_id stable; on release, responses drain in order, none lost or duplicated.
- Pointer fairness: req 1 and 3 held valid, grant to 3 -> next grant 1, then 3; req 0 joining later is granted before wrapping back to 1 when the pointer is past 3.
- Reset mid-stream: assert rst with s1 and s2 both valid -> next cycle rsp_valid=0, mul_x=mul_y=0, first grant after reset goes to requester 0.
- Random soak: random req_valid/rsp_ready, 10k ops, scoreboard per ID -> every accepted operand pair yields exactly one response with the model product, in acceptance order.

Source files
------------

// File: rtl/approx_mul_arbiter.sv
// rtl/approx_mul_arbiter.sv - round-robin arbiter feeding one shared 8x8 approximate multiplier
// Two-stage issue/capture pipeline; responses leave in acceptance order with the requester ID.
module approx_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_x,
    input  logic [NUM_REQ*W-1:0] req_y,
    output logic [W-1:0]         mul_x,
    output logic [W-1:0]         mul_y,
    input  logic [2*W-1:0]       mul_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*W-1:0]       rsp_z
);

    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic           handshake;
    logic           s1_load;
    logic           s2_load;

    logic           s1_valid;
    logic [W-1:0]   s1_x;
    logic [W-1:0]   s1_y;
    logic [IDW-1:0] s1_id;

    logic           s2_valid;
    logic [IDW-1:0] s2_id;
    logic [2*W-1:0] s2_z;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        return IDW'((int'(base) + offset) % NUM_REQ);
    endfunction

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_any && req_valid[rr_index(last_grant, k)]) begin
                grant_any = 1'b1;
                grant_idx = rr_index(last_grant, k);
            end
        end
    end

    assign s2_load = !s2_valid || rsp_ready;
    assign s1_load = !s1_valid || s2_load;

    always_comb begin
        req_ready = '0;
        if (grant_any && s1_load && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign handshake = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDW'(NUM_REQ - 1);
            s1_valid   <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_id      <= '0;
            s2_valid   <= 1'b0;
            s2_id      <= '0;
            s2_z       <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                s2_id    <= s1_id;
                s2_z     <= mul_z;
            end
            if (s1_load) begin
                s1_valid <= handshake;
                if (handshake) begin
                    s1_x       <= req_x[int'(grant_idx)*W +: W];
                    s1_y       <= req_y[int'(grant_idx)*W +: W];
                    s1_id      <= grant_idx;
                    last_grant <= grant_idx;
                end
            end
        end
    end

    // The multiplier is combinational, so its operands come straight from stage 1.
    assign mul_x     = s1_x;
    assign mul_y     = s1_y;
    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_z     = s2_z;

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// tb/tb_approx_mul_arbiter.sv - bench for approx_mul_arbiter with an exact multiplier model
module tb_approx_mul_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic [W-1:0]     mul_x;
    logic [W-1:0]     mul_y;
    logic [2*W-1:0]   mul_z;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_z;

    always #5 clk = ~clk;

    always_comb mul_z = (2*W)'(mul_x) * (2*W)'(mul_y);

    approx_mul_arbiter #(.NUM_REQ(N), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_z     (mul_z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z)
    );

    typedef struct {
        int id;
        int x;
        int y;
        bit in_s2;
    } op_t;

    int vectors     = 0;
    int miscompares = 0;

    op_t    pipe_q[$];
    int     ptr;
    bit     cur_v[N];
    int     cur_x[N];
    int     cur_y[N];

    int     exp_grant;
    bit     exp_accept;
    logic [N-1:0] exp_ready;
    bit     exp_rsp_valid;
    int     exp_rsp_id;
    int     exp_rsp_z;
    bit     exp_s1_busy;
    int     exp_mul_x;
    int     exp_mul_y;

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = cur_v[i];
            req_x[i*W +: W]    = W'(cur_x[i]);
            req_y[i*W +: W]    = W'(cur_y[i]);
        end
    endtask

    task automatic rearm(input int i);
        cur_v[i] = 1'b1;
        cur_x[i] = int'($urandom_range(0, 255));
        cur_y[i] = int'($urandom_range(0, 255));
    endtask

    function automatic bit idle();
        bit any;
        any = 1'b0;
        for (int i = 0; i < N; i++) any = any | cur_v[i];
        return (pipe_q.size() == 0) && !any;
    endfunction

    // Reference: first valid requester after the pointer wins; a slot opens if
    // fewer than two ops are in flight or the response is being taken.
    task automatic model_predict();
        exp_grant = -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (exp_grant < 0 && cur_v[idx]) exp_grant = idx;
        end
        exp_accept = (rst == 1'b0) && (exp_grant >= 0) && (pipe_q.size() < 2 || rsp_ready == 1'b1);
        exp_ready = '0;
        if (exp_accept) exp_ready[exp_grant] = 1'b1;
        exp_rsp_valid = (pipe_q.size() > 0) && pipe_q[0].in_s2;
        exp_rsp_id = 0;
        exp_rsp_z  = 0;
        if (exp_rsp_valid) begin
            exp_rsp_id = pipe_q[0].id;
            exp_rsp_z  = pipe_q[0].x * pipe_q[0].y;
        end
        exp_s1_busy = (pipe_q.size() > 0) && !pipe_q[pipe_q.size()-1].in_s2;
        exp_mul_x = 0;
        exp_mul_y = 0;
        if (exp_s1_busy) begin
            exp_mul_x = pipe_q[pipe_q.size()-1].x;
            exp_mul_y = pipe_q[pipe_q.size()-1].y;
        end
    endtask

    task automatic settle();
        apply_inputs();
        #4;
        model_predict();
    endtask

    task automatic clock_edge();
        apply_inputs();
        model_predict();
        @(posedge clk);
        if (rst) begin
            pipe_q.delete();
            ptr = N - 1;
        end else begin
            if (pipe_q.size() > 0 && pipe_q[0].in_s2 && rsp_ready) void'(pipe_q.pop_front());
            if (pipe_q.size() > 0 && !pipe_q[0].in_s2) begin
                op_t h;
                h = pipe_q[0];
                h.in_s2 = 1'b1;
                pipe_q[0] = h;
            end
            if (exp_accept) begin
                op_t op;
                op.id    = exp_grant;
                op.x     = cur_x[exp_grant];
                op.y     = cur_y[exp_grant];
                op.in_s2 = 1'b0;
                pipe_q.push_back(op);
                ptr = exp_grant;
                cur_v[exp_grant] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int c = 0; c < 50 && !idle(); c++) clock_edge();
        vectors++;
        if (!idle()) begin
            miscompares++;
            $display("FAIL drain_bound: pipeline still busy after 50 cycles, q=%0d want 0", pipe_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) rearm(i);
        settle();
        vectors++;
        if (req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        clock_edge();
        rst = 1'b0;
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
        settle();
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_z !== '0) begin
            miscompares++;
            $display("FAIL reset_rsp: got v=%b id=%0d z=%0d want 0/0/0", rsp_valid, rsp_id, rsp_z);
        end
        vectors++;
        if (mul_x !== '0 || mul_y !== '0) begin
            miscompares++;
            $display("FAIL reset_mul: got x=%0d y=%0d want 0/0", mul_x, mul_y);
        end
        clock_edge();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        cur_v[2] = 1'b1;
        cur_x[2] = 200;
        cur_y[2] = 150;
        settle();
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        clock_edge();
        settle();
        vectors++;
        if (mul_x !== 8'd200 || mul_y !== 8'd150 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_s1: got x=%0d y=%0d v=%b want 200/150/0", mul_x, mul_y, rsp_valid);
        end
        clock_edge();
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_z !== 16'd30000) begin
            miscompares++;
            $display("FAIL single_rsp: got v=%b id=%0d z=%0d want 1/2/30000", rsp_valid, rsp_id, rsp_z);
        end
        clock_edge();
        settle();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got v=%b want 0", rsp_valid);
        end
        clock_edge();
    endtask

    task automatic test_all_four();
        int grants[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
        clock_edge();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) rearm(i);
        for (int c = 0; c < 7; c++) begin
            settle();
            if (c < 5) begin
                vectors++;
                if (req_ready !== N'(1 << grants[c])) begin
                    miscompares++;
                    $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, N'(1 << grants[c]));
                end
            end
            if (c >= 2) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== IDW'((c - 2) % N) || rsp_z !== 16'(exp_rsp_z)) begin
                    miscompares++;
                    $display("FAIL rr_rsp[%0d]: got v=%b id=%0d z=%0d want 1/%0d/%0d",
                             c, rsp_valid, rsp_id, rsp_z, (c - 2) % N, exp_rsp_z);
                end
            end
            clock_edge();
            if (c < 4) begin
                for (int i = 0; i < N; i++) if (!cur_v[i]) rearm(i);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int dut_acc = 0;
        logic [2*W-1:0] held_z;
        logic [IDW-1:0] held_id;
        held_z  = '0;
        held_id = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) rearm(i);
        for (int c = 0; c < 5; c++) begin
            settle();
            if (|(req_valid & req_ready)) dut_acc++;
            vectors++;
            if (req_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
            end
            if (c == 2) begin
                held_z  = rsp_z;
                held_id = rsp_id;
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_z !== 16'(exp_rsp_z)) begin
                    miscompares++;
                    $display("FAIL bp_first: got v=%b z=%0d want 1/%0d", rsp_valid, rsp_z, exp_rsp_z);
                end
            end else if (c > 2) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_z !== held_z || rsp_id !== held_id || req_ready !== '0) begin
                    miscompares++;
                    $display("FAIL bp_hold[%0d]: got v=%b id=%0d z=%0d rdy=%b want 1/%0d/%0d/0000",
                             c, rsp_valid, rsp_id, rsp_z, req_ready, held_id, held_z);
                end
            end
            clock_edge();
        end
        vectors++;
        if (dut_acc !== 2) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d want 2", dut_acc);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && !idle(); c++) begin
            settle();
            if (c == 0) begin
                vectors++;
                if (req_ready === '0) begin
                    miscompares++;
                    $display("FAIL bp_release_accept: got %b want one-hot", req_ready);
                end
            end
            vectors++;
            if (req_ready !== exp_ready || rsp_valid !== exp_rsp_valid ||
                (exp_rsp_valid && (rsp_id !== IDW'(exp_rsp_id) || rsp_z !== 16'(exp_rsp_z)))) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got rdy=%b v=%b id=%0d z=%0d want %b/%b/%0d/%0d",
                         c, req_ready, rsp_valid, rsp_id, rsp_z, exp_ready, exp_rsp_valid, exp_rsp_id, exp_rsp_z);
            end
            clock_edge();
        end
        drain();
    endtask

    task automatic test_fairness();
        logic [N-1:0] want[5] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        rst = 1'b1;
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
        clock_edge();
        rst = 1'b0;
        rsp_ready = 1'b1;
        rearm(1);
        rearm(3);
        for (int c = 0; c < 5; c++) begin
            settle();
            vectors++;
            if (req_ready !== want[c]) begin
                miscompares++;
                $display("FAIL fair_grant[%0d]: got %b want %b", c, req_ready, want[c]);
            end
            clock_edge();
            if (c < 3) begin
                if (!cur_v[1]) rearm(1);
                if (!cur_v[3]) rearm(3);
            end
            if (c == 1) rearm(0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        rearm(0);
        rearm(1);
        clock_edge();
        clock_edge();
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || exp_s1_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_prefill: got v=%b s1=%b want 1/1", rsp_valid, exp_s1_busy);
        end
        rst = 1'b1;
        clock_edge();
        rst = 1'b0;
        for (int i = 0; i < N; i++) rearm(i);
        settle();
        vectors++;
        if (rsp_valid !== 1'b0 || mul_x !== '0 || mul_y !== '0 || req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b x=%0d y=%0d rdy=%b want 0/0/0/0001",
                     rsp_valid, mul_x, mul_y, req_ready);
        end
        clock_edge();
        drain();
    endtask

    task automatic test_soak();
        int dut_acc = 0;
        int dut_rsp = 0;
        int cyc = 0;
        while (dut_acc < 10000 && cyc < 60000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) if (!cur_v[i] && $urandom_range(0, 1) == 1) rearm(i);
            settle();
            if (|(req_valid & req_ready)) dut_acc++;
            if (rsp_valid === 1'b1 && rsp_ready) dut_rsp++;
            vectors++;
            if (req_ready !== exp_ready || rsp_valid !== exp_rsp_valid ||
                (exp_rsp_valid && (rsp_id !== IDW'(exp_rsp_id) || rsp_z !== 16'(exp_rsp_z))) ||
                (exp_s1_busy && (mul_x !== W'(exp_mul_x) || mul_y !== W'(exp_mul_y)))) begin
                miscompares++;
                $display("FAIL soak[%0d]: got rdy=%b v=%b id=%0d z=%0d want %b/%b/%0d/%0d",
                         cyc, req_ready, rsp_valid, rsp_id, rsp_z, exp_ready, exp_rsp_valid, exp_rsp_id, exp_rsp_z);
            end
            clock_edge();
            cyc++;
        end
        vectors++;
        if (dut_acc < 10000) begin
            miscompares++;
            $display("FAIL soak_bound: got %0d accepts want 10000", dut_acc);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 50 && !idle(); c++) begin
            settle();
            if (|(req_valid & req_ready)) dut_acc++;
            if (rsp_valid === 1'b1) dut_rsp++;
            vectors++;
            if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid && rsp_z !== 16'(exp_rsp_z))) begin
                miscompares++;
                $display("FAIL soak_drain[%0d]: got v=%b z=%0d want %b/%0d", c, rsp_valid, rsp_z, exp_rsp_valid, exp_rsp_z);
            end
            clock_edge();
        end
        vectors++;
        if (dut_rsp !== dut_acc) begin
            miscompares++;
            $display("FAIL soak_count: got %0d responses want %0d", dut_rsp, dut_acc);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        ptr       = N - 1;
        for (int i = 0; i < N; i++) begin
            cur_v[i] = 1'b0;
            cur_x[i] = 0;
            cur_y[i] = 0;
        end
        apply_inputs();
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
